// File: rtl/mem_stage.sv
// Memory stage: one outstanding data-memory access with a single-entry writeback register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating the address.
module mem_stage #(
    parameter int WORD     = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [WORD-1:0]     alu_out,
    input  logic [WORD-1:0]     store_data,
    input  logic [4:0]          rd_i,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic                mem_uns,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_LEN-1:0] dmem_addr,
    output logic [WORD-1:0]     dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic                dmem_ack,
    input  logic [WORD-1:0]     dmem_rdata,
    output logic                wb_valid,
    output logic [ADDR_LEN-1:0] wb_pc,
    output logic [WORD-1:0]     wb_data,
    output logic [4:0]          wb_rd,
    output logic                wb_exc,
    input  logic                wb_ready
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [WORD-1:0]     wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          off_q, off_d;
    logic [4:0]          rd_q, rd_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_LEN-1:0] wb_pc_q, wb_pc_d;
    logic [WORD-1:0]     wb_data_q, wb_data_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic                wb_exc_q, wb_exc_d;

    logic [ADDR_LEN-1:0] ea;
    logic                is_mem;
    logic                misalign;
    logic                xfer;
    logic [7:0]          lb;
    logic [15:0]         lh;
    logic [WORD-1:0]     load_val;

    assign ea       = ADDR_LEN'(alu_out);
    assign is_mem   = mem_rd | mem_wr;
    assign ex_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
    assign xfer     = ex_valid && ex_ready;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((mem_size == 2'b01) && ea[0]) ||
                      (mem_size[1] && (ea[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        lb = dmem_rdata[{off_q, 3'b000} +: 8];
        lh = dmem_rdata[{off_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'b00:   load_val = uns_q ? {{(WORD-8){1'b0}}, lb}
                                      : {{(WORD-8){lb[7]}}, lb};
            2'b01:   load_val = uns_q ? {{(WORD-16){1'b0}}, lh}
                                      : {{(WORD-16){lh[15]}}, lh};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        wb_valid_d = wb_valid_q && !wb_ready;
        wb_pc_d    = wb_pc_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_exc_d   = wb_exc_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_i;
                    wb_data_d  = alu_out;
                    wb_rd_d    = rd_i;
                    wb_exc_d   = 1'b0;
                end else if (xfer && misalign) begin
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_i;
                    wb_data_d  = alu_out;
                    wb_rd_d    = 5'd0;
                    wb_exc_d   = 1'b1;
                end else if (xfer) begin
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = mem_wr;
                    addr_d  = {ea[ADDR_LEN-1:2], 2'b00};
                    size_d  = mem_size;
                    uns_d   = mem_uns;
                    off_d   = ea[1:0];
                    rd_d    = rd_i;
                    pc_d    = pc_i;
                    unique case (mem_size)
                        2'b00: begin
                            be_d    = 4'b0001 << ea[1:0];
                            wdata_d = {(WORD/8){store_data[7:0]}};
                        end
                        2'b01: begin
                            be_d    = ea[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {(WORD/16){store_data[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = store_data;
                        end
                    endcase
                end
            end
            ACCESS: begin
                // wb register is guaranteed empty here, so completion can load it
                if (dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_q;
                    wb_exc_d   = 1'b0;
                    wb_data_d  = we_q ? '0 : load_val;
                    wb_rd_d    = we_q ? 5'd0 : rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_exc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_exc_q   <= wb_exc_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_pc      = wb_pc_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign wb_exc     = wb_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores,
// writeback backpressure, reset mid-access and misaligned access.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] pc_i;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  rd_i;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        mem_uns;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exc;
    logic        wb_ready;

    int n_chk;
    int n_pass;

    mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .pc_i      (pc_i),
        .alu_out   (alu_out),
        .store_data(store_data),
        .rd_i      (rd_i),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_size  (mem_size),
        .mem_uns   (mem_uns),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be   (dmem_be),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_exc    (wb_exc),
        .wb_ready  (wb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] r,
                         input logic [31:0] pc);
        ex_valid   = 1'b1;
        mem_rd     = rd;
        mem_wr     = wr;
        mem_size   = sz;
        mem_uns    = uns;
        alu_out    = a;
        store_data = sd;
        rd_i       = r;
        pc_i       = pc;
        step();
        ex_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdata);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b0;
        ex_valid   = 1'b0;
        pc_i       = '0;
        alu_out    = '0;
        store_data = '0;
        rd_i       = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = 2'b00;
        mem_uns    = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        wb_ready   = 1'b1;

        #22;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_exc", 32'(wb_exc), 32'd0);
        reset = 1'b1;
        step();
        check("post_rst_ready", 32'(ex_ready), 32'd1);

        // non-memory op, latency 1
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h40);
        check("alu_valid", 32'(wb_valid), 32'd1);
        check("alu_data", wb_data, 32'h1234);
        check("alu_rd", 32'(wb_rd), 32'd5);
        check("alu_pc", wb_pc, 32'h40);
        check("alu_noreq", 32'(dmem_req), 32'd0);
        step();
        check("alu_drain", 32'(wb_valid), 32'd0);

        // stray ack outside ACCESS
        ack(32'hFFFF_FFFF);
        check("stray_valid", 32'(wb_valid), 32'd0);
        check("stray_req", 32'(dmem_req), 32'd0);

        // load byte signed at 0x103, ack after 3 cycles
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 32'h44);
        check("lb_req", 32'(dmem_req), 32'd1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_be", 32'(dmem_be), 32'h8);
        check("lb_we", 32'(dmem_we), 32'd0);
        check("lb_busy", 32'(ex_ready), 32'd0);
        check("lb_wb_empty", 32'(wb_valid), 32'd0);
        step();
        step();
        check("lb_hold_req", 32'(dmem_req), 32'd1);
        check("lb_hold_addr", dmem_addr, 32'h100);
        ack(32'h8012_3456);
        check("lb_valid", 32'(wb_valid), 32'd1);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_rd", 32'(wb_rd), 32'd7);
        check("lb_pc", wb_pc, 32'h44);
        check("lb_req_drop", 32'(dmem_req), 32'd0);
        step();

        // load byte unsigned
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd8, 32'h48);
        step();
        ack(32'h8012_3456);
        check("lbu_data", wb_data, 32'h0000_0080);
        step();

        // load half signed, upper lane
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd9, 32'h4C);
        check("lh_be", 32'(dmem_be), 32'hC);
        ack(32'h8001_7FFF);
        check("lh_data", wb_data, 32'hFFFF_8001);
        step();

        // store half at 0x202 (rd and wr both set -> store)
        issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 5'd3, 32'h50);
        check("sh_we", 32'(dmem_we), 32'd1);
        check("sh_addr", dmem_addr, 32'h200);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        ack(32'h0);
        check("sh_valid", 32'(wb_valid), 32'd1);
        check("sh_rd", 32'(wb_rd), 32'd0);
        check("sh_data", wb_data, 32'd0);
        step();

        // store byte at 0x101
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_005A, 5'd0, 32'h54);
        check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        ack(32'h0);
        step();

        // store word at 0x300
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF, 5'd0, 32'h58);
        check("sw_be", 32'(dmem_be), 32'hF);
        check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        ack(32'h0);
        step();

        // writeback backpressure then same-edge drain and accept
        wb_ready = 1'b0;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 5'd3, 32'h60);
        check("bp_valid", 32'(wb_valid), 32'd1);
        ex_valid = 1'b1;
        alu_out  = 32'h22;
        rd_i     = 5'd4;
        pc_i     = 32'h64;
        #1;
        check("bp_ready0", 32'(ex_ready), 32'd0);
        step();
        check("bp_hold_data", wb_data, 32'h11);
        check("bp_hold_rd", 32'(wb_rd), 32'd3);
        check("bp_hold_valid", 32'(wb_valid), 32'd1);
        wb_ready = 1'b1;
        #1;
        check("bp_ready1", 32'(ex_ready), 32'd1);
        step();
        ex_valid = 1'b0;
        check("bp_new_valid", 32'(wb_valid), 32'd1);
        check("bp_new_data", wb_data, 32'h22);
        check("bp_new_rd", 32'(wb_rd), 32'd4);
        step();
        check("bp_drained", 32'(wb_valid), 32'd0);

        // reset in the middle of an access
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd6, 32'h70);
        check("rma_req", 32'(dmem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rma_req_drop", 32'(dmem_req), 32'd0);
        #2;
        reset = 1'b1;
        step();
        ack(32'h1234_5678);
        check("rma_ack_ign", 32'(wb_valid), 32'd0);
        check("rma_req_low", 32'(dmem_req), 32'd0);
        check("rma_ready", 32'(ex_ready), 32'd1);

        // word load at 0x301
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 5'd2, 32'h80);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_noreq", 32'(dmem_req), 32'd0);
        check("mis_valid", 32'(wb_valid), 32'd1);
        check("mis_exc", 32'(wb_exc), 32'd1);
        check("mis_data", wb_data, 32'h301);
        check("mis_rd", 32'(wb_rd), 32'd0);
        check("mis_ready", 32'(ex_ready), 32'd1);
`else
        check("mis_req", 32'(dmem_req), 32'd1);
        check("mis_addr", dmem_addr, 32'h300);
        check("mis_be", 32'(dmem_be), 32'hF);
        ack(32'h1234_5678);
        check("mis_data", wb_data, 32'h1234_5678);
        check("mis_exc", 32'(wb_exc), 32'd0);
        check("mis_rd", 32'(wb_rd), 32'd2);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WORD, default 32, data width.
REQ-002 SHALL have parameter ADDR_LEN, default 32, address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ex_valid input 1 and ex_ready output 1: handshake from the execute stage.
REQ-006 SHALL have ports pc_i input ADDR_LEN, alu_out input WORD (result or effective address), store_data input WORD, rd_i input 5.
REQ-007 SHALL have ports mem_rd input 1, mem_wr input 1, mem_size input 2 (00 byte, 01 half, 10/11 word), mem_uns input 1 (zero-extend loads).
REQ-008 SHALL have outputs dmem_req 1, dmem_we 1, dmem_addr ADDR_LEN, dmem_wdata WORD, dmem_be 4, and inputs dmem_ack 1, dmem_rdata WORD.
REQ-009 SHALL have outputs wb_valid 1, wb_pc ADDR_LEN, wb_data WORD, wb_rd 5, wb_exc 1, and input wb_ready 1.

Function
REQ-010 SHALL implement FSM states IDLE and ACCESS.
REQ-011 ex_ready SHALL equal (state==IDLE) && (!wb_valid || wb_ready).
REQ-012 Transfer occurs when ex_valid && ex_ready; no input is sampled otherwise.
REQ-013 Non-memory transfer (mem_rd=0, mem_wr=0): next edge loads wb_data=alu_out, wb_pc=pc_i, wb_rd=rd_i, wb_valid=1; state stays IDLE; latency 1.
REQ-014 Memory transfer: next edge enters ACCESS with dmem_req=1 and dmem_addr/we/wdata/be registered and held stable until ack; mem_wr=1 with mem_rd=1 is treated as a store.
REQ-015 dmem_addr SHALL be alu_out with bits [1:0] zeroed.
REQ-016 Byte: dmem_be=1<<addr[1:0], wdata=byte replicated x4; half: be=0011 (addr[1]=0) or 1100, wdata=half replicated x2; word: be=1111, wdata=store_data.
REQ-017 In ACCESS, dmem_ack=1 at an edge: dmem_req drops, state returns to IDLE, and wb registers load on that edge; minimum memory latency 2 cycles.
REQ-018 Load result SHALL select the lane by addr[1:0]/addr[1], then sign-extend (mem_uns=0) or zero-extend (mem_uns=1) to WORD.
REQ-019 Store completion SHALL produce wb_valid=1, wb_rd=0, wb_data=0.
REQ-020 dmem_ack SHALL be ignored outside ACCESS.
REQ-021 wb_valid SHALL clear on an edge with wb_ready=1 and no new result; a simultaneous drain and new result SHALL leave wb_valid=1 holding the new result.
REQ-022 wb outputs SHALL hold stable while wb_valid && !wb_ready.
REQ-023 The wb register is empty throughout ACCESS; completion never overwrites an undrained result.

Reset
REQ-024 reset=0 SHALL asynchronously force state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_exc=0, wb_pc=0, wb_data=0, wb_rd=0.
REQ-025 Reset during ACCESS SHALL abandon the access; a later stray dmem_ack SHALL be ignored.
REQ-026 After reset release, ex_ready SHALL read 1 on the first cycle.

Configuration
REQ-027 With MEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no dmem_req and, one cycle later, produce wb_valid=1, wb_exc=1, wb_data=alu_out, wb_rd=0, with state staying IDLE.
REQ-028 Without MEM_MISALIGN_TRAP_EN, wb_exc SHALL be tied to 0, and offending low address bits SHALL be ignored per REQ-015/REQ-016.

Verification
REQ-029 Non-memory op, alu_out=0x0000_1234, rd=5, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; no dmem_req.
REQ-030 Load byte signed at addr 0x103, rdata=0x80xx_xxxx, ack after 3 cycles -> dmem_addr=0x100, be=1000, wb_data=0xFFFF_FF80; with mem_uns=1 -> 0x0000_0080.
REQ-031 Store half at addr 0x202, store_data=0xABCD -> dmem_we=1, be=1100, wdata=0xABCD_ABCD; ack -> wb_valid=1, wb_rd=0.
REQ-032 wb_ready=0 with wb_valid=1, then a new ex_valid -> ex_ready=0 and wb outputs held; wb_ready=1 -> same-edge drain and accept.
REQ-033 reset=0 mid-ACCESS -> dmem_req=0 immediately; ack after release ignored, wb_valid stays 0.
REQ-034 MEM_MISALIGN_TRAP_EN defined, word load at 0x301 -> no dmem_req, wb_exc=1, wb_data=0x301.
